fsic_clkdiv_rstseq: RTL and testbench
=====================================

FSIC_CLKDIV_RSTSEQ -- requirements
Module: fsic_clkdiv_rstseq

Interface
REQ-001 The parameters SHALL be:
- HOLD_CYC, default 8: clk cycles div_resetb is held low per reset episode; legal range 1..255.
- LOCK_PER, default 4: divided-clock periods counted before locked; legal range 1..15.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  input clock, identical to the downstream divider's input clock
- rst  in  1  reset, asynchronous, active-high
- soft_req  in  1  asynchronous soft-reset request level (4-phase handshake)
- soft_ack  out  1  soft-reset acknowledge level
- div_resetb  out  1  registered active-low reset driving the downstream div4 divider's resetb
- phase  out  2  mirror of divider phase
- fall_stb  out  1  next clk edge drives the divided clock low
- rise_stb  out  1  next clk edge drives the divided clock high
- locked  out  1  divided clock has run LOCK_PER full periods
REQ-003 The block SHALL use one clock (clk) with rst asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states HOLD, RUN and SOFT, encoded in 2 bits.
REQ-005 In HOLD, a hold counter SHALL increment each cycle; when it reaches HOLD_CYC-1, the next edge SHALL set div_resetb=1, clear the counter and enter RUN.
REQ-006 phase SHALL be 0 whenever div_resetb=0; in RUN it SHALL increment modulo 4 each cycle.
REQ-007 fall_stb SHALL be 1 exactly when state==RUN and phase==0; rise_stb SHALL be 1 exactly when state==RUN and phase==2.
- This matches a divider that resets its output high and toggles on every second edge, starting with the first edge after release.
REQ-008 A lock counter SHALL increment on each rise_stb in RUN and saturate at LOCK_PER; locked SHALL be 1 while the counter equals LOCK_PER.
REQ-009 Leaving RUN SHALL clear locked and the lock counter on the same edge that clears div_resetb.
REQ-010 soft_req SHALL pass through a 2-FF synchronizer giving req_s; a request is req_s==1 and soft_ack==0.
REQ-011 A request in RUN SHALL move the FSM to SOFT and drive div_resetb=0 on the next edge.
REQ-012 SOFT SHALL count exactly like HOLD; on exit it SHALL enter RUN with div_resetb=1 and soft_ack=1 on the same edge.
REQ-013 soft_ack SHALL fall on the edge after req_s is sampled 0; a new request SHALL be accepted only after soft_ack is 0.
REQ-014 A request arising during HOLD SHALL stay pending (level-based) and SHALL be taken on the first RUN cycle.
- Minimum RUN dwell is 1 cycle, with div_resetb=1 for that cycle.
REQ-015 soft_req deasserted before being synchronized SHALL have no effect.
REQ-016 All outputs SHALL be registered or decoded only from registered state; no combinational path from inputs to outputs is allowed.

Reset
REQ-017 While rst=1, the block SHALL hold: state=HOLD, counters=0, div_resetb=0, phase=0, soft_ack=0, locked=0, synchronizer=0.
REQ-018 Assertion of rst SHALL take effect asynchronously, including mid-SOFT; deassertion SHALL restart the full HOLD_CYC sequence.

Configuration
REQ-019 With macro FSIC_RSTSEQ_SOFTRST_EN defined, the soft-reset path (REQ-010..015) SHALL be present.
REQ-020 Without FSIC_RSTSEQ_SOFTRST_EN:
- the synchronizer and SOFT state SHALL be omitted;
- soft_req SHALL be ignored;
- soft_ack SHALL be tied 0;
- all other behaviour SHALL be unchanged.

Structure
REQ-021 A shared package fsic_clk_pkg SHALL hold the FSM state encoding constants, the phase constants PH_FALL=0 and PH_RISE=2, and the HOLD_CYC and LOCK_PER default values.
REQ-022 The synchronizer SHALL be the sub-module fsic_sync2ff (2 flops, reset value 0, async active-high reset).

Verification
REQ-023 Scenario: release rst at cycle 0 with HOLD_CYC=8 -> div_resetb rises on edge 8; phase sequence from then is 0,1,2,3,0; fall_stb high in the first RUN cycle.
REQ-024 Scenario: connect the real divider, run 40 cycles -> each divided-clock edge is preceded by the matching strobe exactly one clk cycle earlier; locked rises after the 4th rise_stb.
REQ-025 Scenario: raise soft_req in RUN -> div_resetb low 3 edges later, held for 8 cycles; soft_ack then 1; drop soft_req -> soft_ack 0 three edges later.
REQ-026 Scenario: hold soft_req high from cycle 2 after rst release -> HOLD completes, one RUN cycle, then SOFT; a single soft_ack results.
REQ-027 Scenario: assert rst mid-SOFT -> all outputs at reset values immediately (no clk edge needed); a full HOLD follows deassertion.
REQ-028 Scenario: build without FSIC_RSTSEQ_SOFTRST_EN and toggle soft_req -> div_resetb stays 1 and soft_ack stays 0.

Source files
------------

// File: rtl/fsic_clk_pkg.sv
// ---------------------------------------------------------------------------
// fsic_clk_pkg
// Shared definitions for the div4 reset sequencer:
//   - FSM state encoding (2 bits)
//   - divider phase constants (PH_FALL, PH_RISE)
//   - default HOLD_CYC / LOCK_PER values
// ---------------------------------------------------------------------------
package fsic_clk_pkg;

  // state | meaning
  // ------+-------------------------------------------------------------
  // HOLD  | power-on / hard reset hold, div_resetb low, counting cycles
  // RUN   | divider released, phase advancing, lock being counted
  // SOFT  | soft-reset hold, div_resetb low, counting like HOLD
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_SOFT = 2'd2
  } state_t;

  localparam logic [1:0] PH_FALL = 2'd0;
  localparam logic [1:0] PH_RISE = 2'd2;

  localparam int HOLD_CYC_DEF = 8;
  localparam int LOCK_PER_DEF = 4;

endpackage

// File: rtl/fsic_sync2ff.sv
// ---------------------------------------------------------------------------
// fsic_sync2ff
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk  in   sampling clock
//   rst  in   asynchronous active-high reset (both flops clear to 0)
//   d    in   asynchronous level
//   q    out  synchronized level
// ---------------------------------------------------------------------------
module fsic_sync2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fsic_clkdiv_rstseq.sv
// ---------------------------------------------------------------------------
// fsic_clkdiv_rstseq
// Reset sequencer for a downstream div4 divider that shares clk. Holds the
// divider in reset for HOLD_CYC cycles, mirrors its phase, predicts its
// edges one clk cycle ahead and reports lock after LOCK_PER divided periods.
//
// Optional feature macro: FSIC_RSTSEQ_SOFTRST_EN
//   defined   -> soft-reset handshake (soft_req/soft_ack) and SOFT state
//   undefined -> soft_req ignored, soft_ack tied 0
//
// Ports:
//   clk         in   input clock (same as the divider's input clock)
//   rst         in   asynchronous active-high reset
//   soft_req    in   asynchronous soft-reset request level (4-phase)
//   soft_ack    out  soft-reset acknowledge level
//   div_resetb  out  registered active-low reset for the divider
//   phase [1:0] out  mirror of the divider phase
//   fall_stb    out  next clk edge drives the divided clock low
//   rise_stb    out  next clk edge drives the divided clock high
//   locked      out  divided clock has run LOCK_PER full periods
//
// state | meaning
// ------+-------------------------------------------------------------
// HOLD  | hard reset hold, div_resetb low for HOLD_CYC cycles
// RUN   | divider running, phase counts 0..3, lock accumulates
// SOFT  | soft reset hold, same timing as HOLD, acks on exit
// ---------------------------------------------------------------------------
module fsic_clkdiv_rstseq
  import fsic_clk_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int LOCK_PER = LOCK_PER_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_req,
  output logic       soft_ack,
  output logic       div_resetb,
  output logic [1:0] phase,
  output logic       fall_stb,
  output logic       rise_stb,
  output logic       locked
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [3:0] LOCK_MAX  = 4'(LOCK_PER);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [3:0] lock_cnt;

`ifdef FSIC_RSTSEQ_SOFTRST_EN
  logic req_s;
  logic ack_q;
  logic soft_take;

  fsic_sync2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (soft_req),
    .q   (req_s)
  );

  // A request is only new while the previous handshake has fully closed.
  assign soft_take = req_s & ~ack_q;
  assign soft_ack  = ack_q;
`else
  logic unused_soft_req;
  assign unused_soft_req = soft_req;
  assign soft_ack        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_HOLD;
      hold_cnt   <= '0;
      lock_cnt   <= '0;
      phase      <= PH_FALL;
      div_resetb <= 1'b0;
`ifdef FSIC_RSTSEQ_SOFTRST_EN
      ack_q      <= 1'b0;
`endif
    end else begin
`ifdef FSIC_RSTSEQ_SOFTRST_EN
      // Ack falls once the request is seen low; a SOFT exit below overrides.
      if (!req_s) ack_q <= 1'b0;
`endif
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt   <= '0;
            div_resetb <= 1'b1;
            state      <= ST_RUN;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        ST_RUN: begin
`ifdef FSIC_RSTSEQ_SOFTRST_EN
          if (soft_take) begin
            state      <= ST_SOFT;
            div_resetb <= 1'b0;
            phase      <= PH_FALL;
            lock_cnt   <= '0;
          end else
`endif
          begin
            phase <= phase + 2'd1;
            if ((phase == PH_RISE) && (lock_cnt != LOCK_MAX))
              lock_cnt <= lock_cnt + 4'd1;
          end
        end

`ifdef FSIC_RSTSEQ_SOFTRST_EN
        ST_SOFT: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt   <= '0;
            div_resetb <= 1'b1;
            ack_q      <= 1'b1;
            state      <= ST_RUN;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
`endif

        default: begin
          state      <= ST_HOLD;
          hold_cnt   <= '0;
          lock_cnt   <= '0;
          phase      <= PH_FALL;
          div_resetb <= 1'b0;
        end
      endcase
    end
  end

  // Strobes look one edge ahead: phase 0 -> divider falls, phase 2 -> rises.
  assign fall_stb = (state == ST_RUN) && (phase == PH_FALL);
  assign rise_stb = (state == ST_RUN) && (phase == PH_RISE);
  assign locked   = (lock_cnt == LOCK_MAX);

endmodule

// File: tb/tb_fsic_clkdiv_rstseq.sv
module tb_fsic_clkdiv_rstseq;

  localparam int HC = 8;
  localparam int LP = 4;
`ifdef FSIC_RSTSEQ_SOFTRST_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       soft_req;
  logic       soft_ack;
  logic       div_resetb;
  logic [1:0] phase;
  logic       fall_stb;
  logic       rise_stb;
  logic       locked;

  fsic_clkdiv_rstseq #(.HOLD_CYC(HC), .LOCK_PER(LP)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_req   (soft_req),
    .soft_ack   (soft_ack),
    .div_resetb (div_resetb),
    .phase      (phase),
    .fall_stb   (fall_stb),
    .rise_stb   (rise_stb),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream div4: output resets high, toggles every second edge,
  // starting with the first edge after release.
  logic div_clk, div_tog;
  always @(posedge clk or negedge div_resetb) begin
    if (!div_resetb) begin
      div_clk <= 1'b1;
      div_tog <= 1'b1;
    end else begin
      if (div_tog) div_clk <= ~div_clk;
      div_tog <= ~div_tog;
    end
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining reset cycles, cycles spent running,
  // and the two-sample delayed request level.
  int m_hold_left;
  int m_run;
  bit m_from_soft;
  bit m_ack;
  bit m_s1, m_s2;

  task automatic m_reset();
    m_hold_left = HC;
    m_run       = 0;
    m_from_soft = 1'b0;
    m_ack       = 1'b0;
    m_s1        = 1'b0;
    m_s2        = 1'b0;
  endtask

  task automatic m_step(input bit req_in);
    bit take;
    take = SOFT_EN && m_s2 && !m_ack;
    if (!m_s2) m_ack = 1'b0;
    if (m_hold_left != 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_run = 0;
        if (m_from_soft) m_ack = 1'b1;
      end
    end else if (take) begin
      m_hold_left = HC;
      m_from_soft = 1'b1;
    end else begin
      m_run++;
    end
    m_s2 = m_s1;
    m_s1 = SOFT_EN ? req_in : 1'b0;
  endtask

  // Compare process: every negedge while enabled.
  bit p_rb, p_div, p_fall, p_rise;
  initial begin
    bit in_run;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        in_run = (m_hold_left == 0);
        chk("div_resetb", div_resetb, in_run);
        chk("phase", phase, in_run ? (m_run % 4) : 0);
        chk("fall_stb", fall_stb, in_run && (m_run % 4 == 0));
        chk("rise_stb", rise_stb, in_run && (m_run % 4 == 2));
        chk("locked", locked, in_run && ((m_run + 1) / 4 >= LP));
        chk("soft_ack", soft_ack, m_ack);
        if (div_resetb && p_rb) begin
          chk("div_fall_follows_stb", p_div && !div_clk, p_fall);
          chk("div_rise_follows_stb", !p_div && div_clk, p_rise);
        end
      end
      p_rb   = div_resetb;
      p_div  = div_clk;
      p_fall = fall_stb;
      p_rise = rise_stb;
    end
  end

  task automatic step();
    @(posedge clk);
    if (!rst) m_step(soft_req);
    @(negedge clk);
  endtask

  // Assert rst between edges and confirm outputs clear without a clk edge.
  task automatic async_rst_check();
    @(posedge clk);
    if (!rst) m_step(soft_req);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk("async_rst_div_resetb", div_resetb, 0);
    chk("async_rst_phase", phase, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_soft_ack", soft_ack, 0);
    chk("async_rst_fall", fall_stb, 0);
    chk("async_rst_rise", rise_stb, 0);
    @(negedge clk);
  endtask

  task automatic release_and_check_hold(input int raise_at);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == raise_at) soft_req = 1'b1;
      if (k == 7) chk("hold_edge7_rb", div_resetb, 0);
      if (k == 8) begin
        chk("hold_edge8_rb", div_resetb, 1);
        chk("first_run_fall", fall_stb, 1);
        chk("first_run_phase", phase, 0);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    soft_req = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_en = 1'b1;

    chk("reset_rb", div_resetb, 0);
    chk("reset_phase", phase, 0);
    chk("reset_ack", soft_ack, 0);
    chk("reset_locked", locked, 0);

    release_and_check_hold(0);

    for (int k = 1; k <= 4; k++) begin
      step();
      chk("phase_seq", phase, k % 4);
      if (k == 2) chk("rise_at_phase2", rise_stb, 1);
    end

    for (int k = 13; k <= 23; k++) begin
      step();
      if (k == 22) chk("locked_before_4th_rise_done", locked, 0);
      if (k == 23) chk("locked_after_4th_rise", locked, 1);
    end

    // Soft-reset handshake (or its absence).
    soft_req = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      step();
`ifdef FSIC_RSTSEQ_SOFTRST_EN
      if (j == 2)  chk("soft_rb_edge2", div_resetb, 1);
      if (j == 3)  chk("soft_rb_edge3", div_resetb, 0);
      if (j == 10) chk("soft_rb_edge10", div_resetb, 0);
      if (j == 10) chk("soft_ack_edge10", soft_ack, 0);
      if (j == 11) chk("soft_rb_edge11", div_resetb, 1);
      if (j == 11) chk("soft_ack_edge11", soft_ack, 1);
`else
      chk("nosoft_rb", div_resetb, 1);
      chk("nosoft_ack", soft_ack, 0);
      soft_req = ~soft_req;
`endif
    end
    soft_req = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step();
`ifdef FSIC_RSTSEQ_SOFTRST_EN
      if (j == 2) chk("ack_hold_edge2", soft_ack, 1);
      if (j == 3) chk("ack_drop_edge3", soft_ack, 0);
`else
      chk("nosoft_ack_drop", soft_ack, 0);
`endif
    end

    // Reset asserted mid-SOFT, then request held from cycle 2 after release.
    soft_req = 1'b1;
    repeat (5) step();
    async_rst_check();
    soft_req = 1'b0;
    @(negedge clk);
    release_and_check_hold(2);
    for (int k = 9; k <= 27; k++) begin
      step();
`ifdef FSIC_RSTSEQ_SOFTRST_EN
      if (k == 9)  chk("pend_rb_edge9", div_resetb, 0);
      if (k == 16) chk("pend_ack_edge16", soft_ack, 0);
      if (k == 17) chk("pend_rb_edge17", div_resetb, 1);
      if (k == 17) chk("pend_ack_edge17", soft_ack, 1);
      if (k == 27) chk("pend_single_ack", soft_ack, 1);
      if (k == 27) chk("pend_no_retrigger", div_resetb, 1);
`else
      if (k == 9)  chk("nosoft_pend_rb", div_resetb, 1);
      if (k == 27) chk("nosoft_pend_ack", soft_ack, 0);
`endif
    end
    soft_req = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_rst_check();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        soft_req = 1'($urandom_range(0, 1));
        rst = 1'b0;
      end else begin
        if ($urandom_range(0, 7) == 0) soft_req = ~soft_req;
        step();
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
